// File: rtl/reg_file_pkg.sv
// Shared defaults and width helpers for the register file with busy scoreboard.
package reg_file_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_IDX  = 0;

  // Width needed to hold a count in the range 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: bits are set at issue and cleared at writeback, with a registered popcount.
// Single cycle update; a same-register issue wins over writeback. No backpressure.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = cnt_w(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_rd,
  output logic [NREGS-1:0] busy_vec,
  output logic [CW-1:0]    busy_cnt
);

  logic set_ok;
  logic clr_ok;
  logic inc;
  logic dec;
  logic [NREGS-1:0] busy_nxt;

  assign set_ok = issue_en && !(ZERO_REG != 0 && issue_rd == AW'(ZERO_IDX));
  assign clr_ok = wb_en    && !(ZERO_REG != 0 && wb_rd    == AW'(ZERO_IDX));

  // The count moves only on real 0->1 / 1->0 transitions of a bit
  assign inc = set_ok && !busy_vec[issue_rd];
  assign dec = clr_ok && busy_vec[wb_rd] && !(set_ok && issue_rd == wb_rd);

  always_comb begin
    busy_nxt = busy_vec;
    if (clr_ok) busy_nxt[wb_rd] = 1'b0;
    if (set_ok) busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busy_nxt;
      busy_cnt <= busy_cnt + CW'(inc) - CW'(dec);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with optional zero register, writeback bypass and busy scoreboard.
// Reads are combinational; writes land on the next edge. No backpressure.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = cnt_w(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            RegWrite,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  output logic [CW-1:0]   busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic wr_ok;
  logic fwd1;
  logic fwd2;
  logic zero1;
  logic zero2;

  assign wr_ok = RegWrite && !(ZERO_REG != 0 && rd == AW'(ZERO_IDX));
  assign fwd1  = BYPASS != 0 && wr_ok && rd == rs1;
  assign fwd2  = BYPASS != 0 && wr_ok && rd == rs2;
  assign zero1 = ZERO_REG != 0 && rs1 == AW'(ZERO_IDX);
  assign zero2 = ZERO_REG != 0 && rs2 == AW'(ZERO_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rd] <= write_data;
    end
  end

  // Reset also masks the bypass path so reads are zero while rst is held
  always_comb begin
    read_data1 = fwd1 ? write_data : regs[rs1];
    read_data2 = fwd2 ? write_data : regs[rs2];
    if (zero1 || rst) read_data1 = '0;
    if (zero2 || rst) read_data2 = '0;
    rs1_busy = busy_vec[rs1] && !fwd1 && !rst;
    rs2_busy = busy_vec[rs2] && !fwd2 && !rst;
  end

  reg_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .issue_en(issue_en),
    .issue_rd(issue_rd),
    .wb_en   (RegWrite),
    .wb_rd   (rd),
    .busy_vec(busy_vec),
    .busy_cnt(busy_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: 32-entry default instance plus a 64-entry instance.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 32-register instance
  logic [4:0]  rs1 = '0, rs2 = '0, issue_rd = '0, rd = '0;
  logic        issue_en = 1'b0, reg_write = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data1, read_data2;
  logic        rs1_busy, rs2_busy;
  logic [5:0]  busy_cnt;

  // 64-register instance
  logic [5:0]  w_rs1 = '0, w_rs2 = '0, w_issue_rd = '0, w_rd = '0;
  logic        w_issue_en = 1'b0, w_reg_write = 1'b0;
  logic [31:0] w_write_data = '0;
  logic [31:0] w_read_data1, w_read_data2;
  logic        w_rs1_busy, w_rs2_busy;
  logic [6:0]  w_busy_cnt;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .read_data1(read_data1), .read_data2(read_data2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .RegWrite(reg_write), .rd(rd), .write_data(write_data),
    .busy_cnt(busy_cnt)
  );

  reg_file_sb #(.NREGS(64)) dut64 (
    .clk(clk), .rst(rst), .rs1(w_rs1), .rs2(w_rs2),
    .read_data1(w_read_data1), .read_data2(w_read_data2),
    .rs1_busy(w_rs1_busy), .rs2_busy(w_rs2_busy),
    .issue_en(w_issue_en), .issue_rd(w_issue_rd),
    .RegWrite(w_reg_write), .rd(w_rd), .write_data(w_write_data),
    .busy_cnt(w_busy_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0; reg_write = 1'b0;
    w_issue_en = 1'b0; w_reg_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rs1 = 5'd5; reg_write = 1'b1; rd = 5'd5; write_data = 32'hFFFF_FFFF;
    #2;
    checks++; if (read_data1 !== 32'h0) begin failures++; $display("FAIL rst_rd1 got=%h exp=%h", read_data1, 32'h0); end
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL rst_busy1 got=%b exp=0", rs1_busy); end
    checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", busy_cnt); end
    tick(); idle(); rst = 1'b0;
    reg_write = 1'b1; rd = 5'd5; write_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (read_data1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_r5 got=%h exp=deadbeef", read_data1); end
    tick(); idle(); #1;
    checks++; if (read_data1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stored_r5 got=%h exp=deadbeef", read_data1); end
  endtask

  task automatic test_zero_reg();
    rs1 = 5'd0; reg_write = 1'b1; rd = 5'd0; write_data = 32'h1234;
    #1;
    checks++; if (read_data1 !== 32'h0) begin failures++; $display("FAIL r0_bypass got=%h exp=0", read_data1); end
    tick(); idle(); #1;
    checks++; if (read_data1 !== 32'h0) begin failures++; $display("FAIL r0_stored got=%h exp=0", read_data1); end
    issue_en = 1'b1; issue_rd = 5'd0;
    tick(); idle(); #1;
    checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL r0_issue_cnt got=%0d exp=0", busy_cnt); end
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL r0_busy got=%b exp=0", rs1_busy); end
  endtask

  task automatic test_bypass();
    issue_en = 1'b1; issue_rd = 5'd7;
    tick(); idle(); rs2 = 5'd7; #1;
    checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL byp_cnt1 got=%0d exp=1", busy_cnt); end
    checks++; if (rs2_busy !== 1'b1) begin failures++; $display("FAIL byp_busy_pre got=%b exp=1", rs2_busy); end
    reg_write = 1'b1; rd = 5'd7; write_data = 32'hA5A5_A5A5;
    #1;
    checks++; if (read_data2 !== 32'hA5A5_A5A5) begin failures++; $display("FAIL byp_rd2 got=%h exp=a5a5a5a5", read_data2); end
    checks++; if (rs2_busy !== 1'b0) begin failures++; $display("FAIL byp_busy_fwd got=%b exp=0", rs2_busy); end
    tick(); idle(); #1;
    checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL byp_cnt0 got=%0d exp=0", busy_cnt); end
    checks++; if (read_data2 !== 32'hA5A5_A5A5) begin failures++; $display("FAIL byp_stored got=%h exp=a5a5a5a5", read_data2); end
  endtask

  task automatic test_scoreboard();
    rs1 = 5'd3; issue_en = 1'b1; issue_rd = 5'd3;
    #1;
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL sb_same_cycle got=%b exp=0", rs1_busy); end
    tick(); idle(); #1;
    checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL sb_cnt1 got=%0d exp=1", busy_cnt); end
    checks++; if (rs1_busy !== 1'b1) begin failures++; $display("FAIL sb_r3_busy got=%b exp=1", rs1_busy); end
    issue_en = 1'b1; issue_rd = 5'd4;
    tick(); idle(); #1;
    checks++; if (busy_cnt !== 6'd2) begin failures++; $display("FAIL sb_cnt2 got=%0d exp=2", busy_cnt); end
    issue_en = 1'b1; issue_rd = 5'd9; reg_write = 1'b1; rd = 5'd3; write_data = 32'h33;
    tick(); idle(); rs1 = 5'd3; rs2 = 5'd9; #1;
    checks++; if (busy_cnt !== 6'd2) begin failures++; $display("FAIL sb_net0 got=%0d exp=2", busy_cnt); end
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL sb_r3_clr got=%b exp=0", rs1_busy); end
    checks++; if (rs2_busy !== 1'b1) begin failures++; $display("FAIL sb_r9_set got=%b exp=1", rs2_busy); end
  endtask

  task automatic test_same_reg();
    issue_en = 1'b1; issue_rd = 5'd6;
    tick(); idle(); #1;
    checks++; if (busy_cnt !== 6'd3) begin failures++; $display("FAIL same_cnt3 got=%0d exp=3", busy_cnt); end
    issue_en = 1'b1; issue_rd = 5'd6; reg_write = 1'b1; rd = 5'd6; write_data = 32'h66;
    tick(); idle(); rs1 = 5'd6; #1;
    checks++; if (rs1_busy !== 1'b1) begin failures++; $display("FAIL same_busy got=%b exp=1", rs1_busy); end
    checks++; if (busy_cnt !== 6'd3) begin failures++; $display("FAIL same_cnt got=%0d exp=3", busy_cnt); end
    checks++; if (read_data1 !== 32'h66) begin failures++; $display("FAIL same_data got=%h exp=66", read_data1); end
    reg_write = 1'b1; rd = 5'd10; write_data = 32'hAA;
    tick(); idle(); rs2 = 5'd10; #1;
    checks++; if (busy_cnt !== 6'd3) begin failures++; $display("FAIL nonbusy_cnt got=%0d exp=3", busy_cnt); end
    checks++; if (rs2_busy !== 1'b0) begin failures++; $display("FAIL nonbusy_busy got=%b exp=0", rs2_busy); end
    checks++; if (read_data2 !== 32'hAA) begin failures++; $display("FAIL nonbusy_data got=%h exp=aa", read_data2); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 32; i++) begin
      issue_en = 1'b1; issue_rd = 5'(i);
      tick();
    end
    idle(); #1;
    checks++; if (busy_cnt !== 6'd31) begin failures++; $display("FAIL full_cnt got=%0d exp=31", busy_cnt); end
    rs1 = 5'd5; rs2 = 5'd4; #2;
    rst = 1'b1; #1;
    checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d exp=0", busy_cnt); end
    checks++; if (read_data1 !== 32'h0) begin failures++; $display("FAIL mid_rst_rd1 got=%h exp=0", read_data1); end
    checks++; if (rs2_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy2 got=%b exp=0", rs2_busy); end
    tick(); rst = 1'b0; #1;
    checks++; if (read_data1 !== 32'h0) begin failures++; $display("FAIL post_rst_rd1 got=%h exp=0", read_data1); end
  endtask

  task automatic test_nregs64();
    rst = 1'b1; w_rs1 = 6'd5; #2;
    checks++; if (w_read_data1 !== 32'h0) begin failures++; $display("FAIL w_rst_rd1 got=%h exp=0", w_read_data1); end
    checks++; if (w_busy_cnt !== 7'd0) begin failures++; $display("FAIL w_rst_cnt got=%0d exp=0", w_busy_cnt); end
    tick(); rst = 1'b0;
    w_reg_write = 1'b1; w_rd = 6'd5; w_write_data = 32'hDEAD_BEEF;
    tick(); idle(); #1;
    checks++; if (w_read_data1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL w_r5 got=%h exp=deadbeef", w_read_data1); end
    w_issue_en = 1'b1; w_issue_rd = 6'd33;
    tick(); idle(); #1;
    checks++; if (w_busy_cnt !== 7'd1) begin failures++; $display("FAIL w_cnt1 got=%0d exp=1", w_busy_cnt); end
    w_issue_en = 1'b1; w_issue_rd = 6'd34;
    tick(); idle(); #1;
    checks++; if (w_busy_cnt !== 7'd2) begin failures++; $display("FAIL w_cnt2 got=%0d exp=2", w_busy_cnt); end
    w_issue_en = 1'b1; w_issue_rd = 6'd60; w_reg_write = 1'b1; w_rd = 6'd33; w_write_data = 32'h4040;
    tick(); idle(); w_rs1 = 6'd33; w_rs2 = 6'd60; #1;
    checks++; if (w_busy_cnt !== 7'd2) begin failures++; $display("FAIL w_net0 got=%0d exp=2", w_busy_cnt); end
    checks++; if (w_rs1_busy !== 1'b0) begin failures++; $display("FAIL w_r33_clr got=%b exp=0", w_rs1_busy); end
    checks++; if (w_rs2_busy !== 1'b1) begin failures++; $display("FAIL w_r60_set got=%b exp=1", w_rs2_busy); end
    checks++; if (w_read_data1 !== 32'h4040) begin failures++; $display("FAIL w_r33_data got=%h exp=4040", w_read_data1); end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_same_reg();
    test_reset_mid();
    test_nregs64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
